// File: rtl/addsub16_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : addsub16_arb
// Purpose  : Round-robin arbiter/sequencer sharing one ADDSUB16 accumulator
//            between four requesters. Each granted operation runs
//            ISSUE -> CAPT -> RESP, and the captured accumulator value goes
//            back to the winner together with a DONE pulse.
// Options  : ADDSUB16_ARB_OVF_EN - adds the signed-overflow output ovf_o
// Revision : 1.0 - initial release
// ============================================================================
module addsub16_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   op_i,
  input  logic [N_REQ*W-1:0] din_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               done_o,
  output logic [1:0]         done_id_o,
  output logic [W-1:0]       result_o,
  output logic               as_en_o,
  output logic               as_set_o,
  output logic [W-1:0]       as_data_o,
  input  logic [W-1:0]       as_out_i
`ifdef ADDSUB16_ARB_OVF_EN
  ,
  output logic               ovf_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q;      // round-robin search start
  logic [1:0]  wid_q;      // index of the current winner
  logic [W-1:0] data_q;    // operand latched at the arbitration edge
  logic        op_q;       // opcode latched at the arbitration edge
  logic [W-1:0] result_q;

  logic [2:0]  pick;       // {valid, index}
  logic        win_vld;
  logic [1:0]  win_idx;
  logic        arb_fire;

  // Scan p, p+1, p+2, p+3 (mod 4); the first set request wins. The loop runs
  // from the far end so the nearest hit is the last one written.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign pick     = rr_pick(req_i, ptr_q);
  assign win_vld  = pick[2];
  assign win_idx  = pick[1:0];
  // Arbitration happens only from IDLE or RESP, which gives back-to-back
  // operations every three cycles.
  assign arb_fire = en_i && win_vld && ((state_q == S_IDLE) || (state_q == S_RESP));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    gnt_o   = '0;
    as_en_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_fire) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt_o   = {{(N_REQ-1){1'b0}}, 1'b1} << wid_q;
        as_en_o = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        done_o  = 1'b1;
        state_d = arb_fire ? S_ISSUE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latch the winner's operand/opcode and advance the pointer on a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= 2'd0;
      wid_q  <= 2'd0;
      data_q <= '0;
      op_q   <= 1'b0;
    end else if (arb_fire) begin
      ptr_q  <= win_idx + 2'd1;
      wid_q  <= win_idx;
      data_q <= din_i[win_idx*W +: W];
      op_q   <= op_i[win_idx];
    end
  end

  // Capture the accumulator once it has absorbed the issued operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (state_q == S_CAPT) begin
      result_q <= as_out_i;
    end
  end

`ifdef ADDSUB16_ARB_OVF_EN
  logic [W-1:0] pre_q;     // accumulator value before the operation
  logic         ovf_q;
  logic         ovf_calc;

  // Signed overflow: operands agree in sign (add) or differ (subtract) and
  // the result sign departs from the pre-operation sign.
  assign ovf_calc = (op_q ? (pre_q[W-1] == data_q[W-1]) : (pre_q[W-1] != data_q[W-1]))
                    && (as_out_i[W-1] != pre_q[W-1]);

  // Sample the pre-operation value in ISSUE, evaluate overflow in CAPT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        pre_q <= as_out_i;
      end
      if (state_q == S_CAPT) begin
        ovf_q <= ovf_calc;
      end
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign done_id_o = wid_q;
  assign result_o  = result_q;
  assign as_set_o  = op_q;
  assign as_data_o = data_q;

endmodule
`default_nettype wire

// File: doc/addsub16_arb.md
# addsub16_arb

Round-robin arbiter and sequencer sharing one ADDSUB16 accumulator between four requesters. Each requester posts a 16-bit operand and an add/subtract opcode. The block grants one requester at a time and drives the accumulator's EN/SET/DATA for exactly one cycle. It then captures the accumulator OUTPUT and returns it to the winner with a completion pulse. It sits between the requesting client blocks and the single ADDSUB16 instance.

## Interface
- N_REQ, 4: requester count; fixed at 4, and the round-robin logic is written for 4.
- W, 16: operand and accumulator width.
- CLK  in  1  rising-edge clock; the single clock of the block.
- RST  in  1  reset, asynchronous assert, active-low; synchronous deassert is handled upstream.
- EN  in  1  arbitration enable; while low, no new grant is made and any in-flight operation completes.
- REQ  in  4  request per requester; level, held until the matching GNT bit pulses.
- OP  in  4  opcode per requester: 1 = add, 0 = subtract.
- DIN  in  64  operands, packed; requester i occupies DIN[16i+15:16i].
- GNT  out  4  one-hot grant pulse, 1 cycle.
- DONE  out  1  completion pulse, 1 cycle.
- DONE_ID  out  2  index of the completed requester; valid when DONE=1.
- RESULT  out  16  accumulator value after the operation; held until the next DONE.
- AS_EN  out  1  accumulator EN.
- AS_SET  out  1  accumulator SET: 1 = add DATA, 0 = subtract DATA.
- AS_DATA  out  16  accumulator DATA.
- AS_OUT  in  16  accumulator OUTPUT; updates on the CLK edge that samples AS_EN=1.

## Operation
- FSM states are IDLE, ISSUE, CAPT and RESP.
- IDLE: when EN=1 and REQ!=0, pick the winner w, latch DIN[w], OP[w] and w, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: assert GNT[w]=1 and AS_EN=1; drive AS_DATA and AS_SET from the latched values. Always proceeds to CAPT.
- CAPT: assert AS_EN=0 and register AS_OUT into RESULT. Go to RESP.
- RESP: assert DONE=1 and DONE_ID=w.
  - Arbitration is evaluated in this state exactly as in IDLE.
  - With a winner, go directly to ISSUE; otherwise go to IDLE.
- Round-robin pointer p:
  - Search order is p, p+1, p+2, p+3, all mod 4.
  - After a grant to w, p becomes (w+1) mod 4.
  - The reset value of p is 0.
- Operands and opcode are latched at the arbitration edge. Changes to DIN or OP after that edge do not affect the issued operation.
- A REQ bit that falls before its grant is a withdrawn request, with no side effect.
- A REQ still high in the cycle after its GNT counts as a new request.
- Arithmetic is performed by the accumulator and is 16-bit modular: wrap-around, no saturation. This block does no arithmetic except the optional overflow flag.
- EN falling mid-operation does not abort the operation. ISSUE, CAPT and RESP still complete, and no new grant is made.

## Timing
- Reset values: GNT=0, DONE=0, DONE_ID=0, RESULT=0, AS_EN=0, AS_SET=0, AS_DATA=0, p=0, state IDLE.
- Reset mid-operation:
  - All outputs go to their reset values immediately (asynchronously).
  - No DONE is issued for the aborted operation.
  - If AS_EN was high, it drops without waiting for a clock edge.
- Cycle sequence, taking cycle 0 as IDLE with REQ seen:
  - GNT and AS_EN are high in cycle 1.
  - RESULT is loaded at the end of cycle 2.
  - DONE is high in cycle 3.
- Request-to-DONE latency is 3 cycles.
- Under continuous requests, there is one operation every 3 cycles: ISSUE recurs in cycles 1, 4, 7, and so on.
- AS_EN is never high for two consecutive cycles.
- GNT and AS_EN are always coincident.
- All outputs are registered, or decoded from the state register only.

## Configuration
- ADDSUB16_ARB_OVF_EN defined:
  - Adds output OVF (1 bit), valid with DONE and held like RESULT; reset value 0.
  - AS_OUT is sampled in ISSUE as the pre-operation value a. With d = AS_DATA and r = RESULT:
    - add: OVF = (a[15]==d[15]) and (r[15]!=a[15]).
    - subtract: OVF = (a[15]!=d[15]) and (r[15]!=a[15]).
- ADDSUB16_ARB_OVF_EN undefined: the OVF port and its logic are absent; all other behaviour is identical.

## Test plan
The bench accumulator model resets to 0.
- Reset, then REQ=4'b0001, OP[0]=1, DIN[0]=16'h0007 -> GNT=4'b0001 in cycle 1, AS_EN=1, AS_SET=1, AS_DATA=16'h0007; DONE in cycle 3 with DONE_ID=0, RESULT=16'h0007.
- REQ=4'b1111 held, all OP=1, DIN[i]=i+1 -> grant order 0,1,2,3,0; GNT pulses 3 cycles apart; RESULTs 16'h0001, 16'h0003, 16'h0006, 16'h000A, 16'h000B.
- After the above, p=1 and REQ=4'b0101 -> requester 2 is granted before requester 0.
- Accumulator at 16'h0002, requester 1 issues subtract of 16'h0005 -> RESULT=16'hFFFD (wrap-around). With ADDSUB16_ARB_OVF_EN: OVF=0. Accumulator at 16'h7FFF plus 16'h0001 -> RESULT=16'h8000, OVF=1.
- EN=0 with REQ=4'b0010 -> no GNT and AS_EN stays 0; EN=1 -> grant next cycle. EN dropped during CAPT -> DONE still pulses and no further grant.
- RST low in the ISSUE cycle -> AS_EN and GNT go to 0 before the next edge. No DONE follows. After release with REQ held, the grant restarts from p=0.
